// File: rtl/rp_testing_pkg.sv
// Shared types and constants for the rp_testing measurement sequencer.
package rp_testing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_MEAS,
    ST_DONE
  } state_t;

  localparam logic [3:0] LED_PULSE  = 4'b0001;
  localparam logic [3:0] LED_SETTLE = 4'b0010;
  localparam logic [3:0] LED_MEAS   = 4'b0100;
  localparam logic [3:0] LED_DONE   = 4'b1000;

  // Bits needed to hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rp_debounce.sv
// Button conditioner: 2-FF synchronizer, consecutive-mismatch debounce,
// and a one-cycle registered event on each 0->1 of the debounced level.
module rp_debounce
  import rp_testing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic evt
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [DW-1:0] cnt;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      evt   <= 1'b0;
    end else if (sync_p1 != level) begin
      if (cnt == LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        evt   <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
        evt <= 1'b0;
      end
    end else begin
      cnt <= '0;
      evt <= 1'b0;
    end
  end

endmodule

// File: rtl/rp_test_sequencer.sv
// Button-triggered pulse / settle / edge-count sequencer with paged LED readout.
module rp_test_sequencer
  import rp_testing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 8,
  parameter int SETTLE_CYCLES   = 16,
  parameter int WINDOW_CYCLES   = 1024,
  parameter int CNT_W           = 16
) (
  input  logic             pll_inst1_CLKOUT0,
  input  logic             rst_n,
  input  logic             btn_start,
  input  logic             btn_page,
  input  logic             data_in,
  output logic             to_osc,
  output logic [3:0]       LED,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid
);

  localparam int PH_MAX =
    (PULSE_CYCLES > SETTLE_CYCLES)
      ? ((PULSE_CYCLES > WINDOW_CYCLES) ? PULSE_CYCLES : WINDOW_CYCLES)
      : ((SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES);
  localparam int PH_W   = cnt_width(PH_MAX);
  localparam int NPAGES = CNT_W / 4;
  localparam int PAGE_W = cnt_width(NPAGES);

  logic              clk;
  logic              start_evt;
  logic              page_evt;
  logic              data_p0;
  logic              data_p1;
  logic              data_p2;
  logic              rise;
  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [CNT_W-1:0]  count;
  logic [PAGE_W-1:0] page;
  logic [3:0]        nibble;

  assign clk    = pll_inst1_CLKOUT0;
  assign rise   = data_p1 & ~data_p2;
  assign nibble = 4'(result >> {page, 2'b00});

  rp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_start),
    .evt   (start_evt)
  );

  rp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_page (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_page),
    .evt   (page_evt)
  );

  // Synchronize data_in and keep its previous sample every cycle, so an edge
  // straddling window entry is still seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0 <= 1'b0;
      data_p1 <= 1'b0;
      data_p2 <= 1'b0;
    end else begin
      data_p0 <= data_in;
      data_p1 <= data_p0;
      data_p2 <= data_p1;
    end
  end

  // Run sequencer; one phase counter is reloaded on each timed-state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      to_osc       <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      page         <= '0;
      phase        <= '0;
      count        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_evt) begin
            state        <= ST_PULSE;
            to_osc       <= 1'b1;
            busy         <= 1'b1;
            result_valid <= 1'b0;
            page         <= '0;
            count        <= '0;
            phase        <= PH_W'(PULSE_CYCLES - 1);
          end else if (page_evt) begin
            page <= (page == PAGE_W'(NPAGES - 1)) ? '0 : page + 1'b1;
          end
        end
        ST_PULSE: begin
          if (phase == '0) begin
            state  <= ST_SETTLE;
            to_osc <= 1'b0;
            phase  <= PH_W'(SETTLE_CYCLES - 1);
          end else begin
            phase <= phase - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (phase == '0) begin
            state <= ST_MEAS;
            phase <= PH_W'(WINDOW_CYCLES - 1);
          end else begin
            phase <= phase - 1'b1;
          end
        end
        ST_MEAS: begin
          if (rise && (count != {CNT_W{1'b1}})) count <= count + 1'b1;
          if (phase == '0) state <= ST_DONE;
          else             phase <= phase - 1'b1;
        end
        ST_DONE: begin
          result       <= count;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered LED: status code while running, selected result nibble when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LED <= 4'b0000;
    end else begin
      case (state)
        ST_PULSE:  LED <= LED_PULSE;
        ST_SETTLE: LED <= LED_SETTLE;
        ST_MEAS:   LED <= LED_MEAS;
        ST_DONE:   LED <= LED_DONE;
        default:   LED <= result_valid ? nibble : 4'b0000;
      endcase
    end
  end

endmodule

// File: tb/tb_rp_test_sequencer.sv
// Directed bench for rp_test_sequencer using three parameterisations.
module tb_rp_test_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_in = 1'b0;
  logic bs_a = 1'b0, bp_a = 1'b0;
  logic bs_b = 1'b0, bp_b = 1'b0;
  logic bs_c = 1'b0, bp_c = 1'b0;

  logic        osc_a, busy_a, rv_a;
  logic [3:0]  led_a;
  logic [15:0] res_a;
  logic        osc_b, busy_b, rv_b;
  logic [3:0]  led_b;
  logic [3:0]  res_b;
  logic        osc_c, busy_c, rv_c;
  logic [3:0]  led_c;
  logic [15:0] res_c;

  int tests = 0;
  int fails = 0;
  int per = 0;
  int dph = 0;
  int osc_c_rises = 0;
  logic osc_c_q = 1'b0;

  always #5 clk = ~clk;

  rp_test_sequencer #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .SETTLE_CYCLES(2),
                      .WINDOW_CYCLES(20), .CNT_W(16)) u_a (
    .pll_inst1_CLKOUT0(clk), .rst_n(rst_n), .btn_start(bs_a), .btn_page(bp_a),
    .data_in(data_in), .to_osc(osc_a), .LED(led_a), .busy(busy_a),
    .result(res_a), .result_valid(rv_a));

  rp_test_sequencer #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .SETTLE_CYCLES(2),
                      .WINDOW_CYCLES(40), .CNT_W(4)) u_b (
    .pll_inst1_CLKOUT0(clk), .rst_n(rst_n), .btn_start(bs_b), .btn_page(bp_b),
    .data_in(data_in), .to_osc(osc_b), .LED(led_b), .busy(busy_b),
    .result(res_b), .result_valid(rv_b));

  rp_test_sequencer #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .SETTLE_CYCLES(2),
                      .WINDOW_CYCLES(9320), .CNT_W(16)) u_c (
    .pll_inst1_CLKOUT0(clk), .rst_n(rst_n), .btn_start(bs_c), .btn_page(bp_c),
    .data_in(data_in), .to_osc(osc_c), .LED(led_c), .busy(busy_c),
    .result(res_c), .result_valid(rv_c));

  // Square-wave source on data_in: per==2 toggles each cycle, per==4 every other cycle.
  always @(negedge clk) begin
    dph = dph + 1;
    if (per == 2) data_in = ~data_in;
    else if (per == 4) begin
      if (dph % 2 == 0) data_in = ~data_in;
    end else data_in = 1'b0;
  end

  // Count to_osc rising edges of instance c.
  always @(negedge clk) begin
    if (osc_c && !osc_c_q) osc_c_rises = osc_c_rises + 1;
    osc_c_q = osc_c;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int sel, input logic v);
    case (sel)
      0: bs_a = v;
      1: bs_b = v;
      2: bs_c = v;
      default: bp_c = v;
    endcase
  endtask

  task automatic press(input int sel);
    @(negedge clk);
    set_btn(sel, 1'b1);
    tick(8);
    set_btn(sel, 1'b0);
  endtask

  task automatic test_reset;
    int found;
    rst_n = 1'b0;
    per = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bs_a = 1'($urandom_range(0, 1)); bp_a = 1'($urandom_range(0, 1));
      bs_b = 1'($urandom_range(0, 1)); bs_c = 1'($urandom_range(0, 1));
      bp_c = 1'($urandom_range(0, 1));
    end
    tick(1);
    tests++; if (osc_a !== 1'b0) begin fails++; $display("FAIL reset_to_osc got %b want 0", osc_a); end
    tests++; if (led_a !== 4'h0) begin fails++; $display("FAIL reset_led got %h want 0", led_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_a); end
    tests++; if (res_a !== 16'h0) begin fails++; $display("FAIL reset_result got %h want 0", res_a); end
    tests++; if (rv_a !== 1'b0) begin fails++; $display("FAIL reset_result_valid got %b want 0", rv_a); end
    bs_a = 0; bp_a = 0; bs_b = 0; bs_c = 0; bp_c = 0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    // start a run and pull reset while to_osc is high
    bs_a = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      if (osc_a === 1'b1) found = 1;
    end
    tests++; if (found == 0) begin fails++; $display("FAIL reset_pulse_seen got none want to_osc=1 within 30 cycles"); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (osc_a !== 1'b0) begin fails++; $display("FAIL reset_async_to_osc got %b want 0", osc_a); end
    bs_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(10);
  endtask

  task automatic test_debounce;
    int busy_cnt, hi_cnt, rises;
    logic q;
    @(negedge clk);
    bs_a = 1'b1;
    tick(2);
    bs_a = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
    end
    tests++; if (busy_cnt != 0) begin fails++; $display("FAIL debounce_short busy cycles got %0d want 0", busy_cnt); end
    busy_cnt = 0; hi_cnt = 0; rises = 0; q = 1'b0;
    @(negedge clk);
    bs_a = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (osc_a) hi_cnt++;
      if (osc_a && !q) rises++;
      q = osc_a;
      if (busy_a) busy_cnt++;
      if (i == 9) bs_a = 1'b0;
    end
    tests++; if (rises != 1) begin fails++; $display("FAIL debounce_runs got %0d want 1", rises); end
    tests++; if (hi_cnt != 3) begin fails++; $display("FAIL debounce_pulse_len got %0d want 3", hi_cnt); end
    tests++; if (busy_cnt != 26) begin fails++; $display("FAIL debounce_busy_len got %0d want 26", busy_cnt); end
    tests++; if (rv_a !== 1'b1 || res_a !== 16'h0) begin
      fails++; $display("FAIL debounce_result got rv=%b res=%h want rv=1 res=0000", rv_a, res_a);
    end
  endtask

  task automatic test_count;
    int found;
    per = 4;
    tick(4);
    press(0);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (rv_a === 1'b1) found = 1;
    end
    tests++; if (found == 0) begin fails++; $display("FAIL count_timeout got no result_valid want 1 within 100 cycles"); end
    tests++; if (res_a !== 16'd5) begin fails++; $display("FAIL count_result got %0d want 5", res_a); end
    tests++; if (led_a !== 4'b1000) begin fails++; $display("FAIL count_led_done got %b want 1000", led_a); end
    tick(1);
    tests++; if (led_a !== 4'b0101) begin fails++; $display("FAIL count_led_page0 got %b want 0101", led_a); end
  endtask

  task automatic test_saturation;
    int found;
    per = 2;
    press(1);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (rv_b === 1'b1) found = 1;
    end
    tests++; if (found == 0) begin fails++; $display("FAIL sat_timeout got no result_valid want 1 within 200 cycles"); end
    tests++; if (res_b !== 4'hF) begin fails++; $display("FAIL sat_result got %0d want 15", res_b); end
    tick(1);
    tests++; if (led_b !== 4'hF) begin fails++; $display("FAIL sat_led got %b want 1111", led_b); end
  endtask

  task automatic test_paging;
    int found, base;
    logic [3:0] exp_nib [4];
    exp_nib[0] = 4'h3; exp_nib[1] = 4'h2; exp_nib[2] = 4'h1; exp_nib[3] = 4'h4;
    per = 2;
    base = osc_c_rises;
    press(2);
    tick(100);
    press(2);
    found = 0;
    for (int i = 0; i < 10000 && found == 0; i++) begin
      @(negedge clk);
      if (rv_c === 1'b1) found = 1;
    end
    tests++; if (found == 0) begin fails++; $display("FAIL page_timeout got no result_valid want 1 within 10000 cycles"); end
    tests++; if (osc_c_rises - base != 1) begin fails++; $display("FAIL page_no_restart runs got %0d want 1", osc_c_rises - base); end
    tests++; if (res_c !== 16'h1234) begin fails++; $display("FAIL page_result got %h want 1234", res_c); end
    tick(1);
    tests++; if (led_c !== 4'h4) begin fails++; $display("FAIL page_led_p0 got %h want 4", led_c); end
    for (int p = 0; p < 4; p++) begin
      press(3);
      tick(4);
      tests++; if (led_c !== exp_nib[p]) begin
        fails++; $display("FAIL page_led_press%0d got %h want %h", p + 1, led_c, exp_nib[p]);
      end
    end
    @(negedge clk);
    bs_c = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (busy_c === 1'b1) found = 1;
    end
    tests++; if (found == 0 || rv_c !== 1'b0) begin
      fails++; $display("FAIL page_restart_clear got busy_seen=%0d rv=%b want 1/0", found, rv_c);
    end
    tick(1);
    bs_c = 1'b0;
    tests++; if (led_c !== 4'b0001) begin fails++; $display("FAIL page_restart_led got %b want 0001", led_c); end
  endtask

  task automatic test_reset_measure;
    int found;
    per = 4;
    press(0);
    tick(8);
    tests++; if (led_a !== 4'b0100) begin fails++; $display("FAIL rstm_in_measure led got %b want 0100", led_a); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++; if (busy_a !== 1'b0 || res_a !== 16'h0 || rv_a !== 1'b0 || led_a !== 4'h0) begin
      fails++; $display("FAIL rstm_cleared got busy=%b res=%h rv=%b led=%h want 0/0000/0/0", busy_a, res_a, rv_a, led_a);
    end
    found = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy_a === 1'b1) found = 1;
    end
    tests++; if (found != 0) begin fails++; $display("FAIL rstm_idle got busy after reset want idle"); end
    press(0);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (rv_a === 1'b1) found = 1;
    end
    tests++; if (found == 0 || res_a !== 16'd5) begin
      fails++; $display("FAIL rstm_rerun got valid=%0d res=%0d want 1/5", found, res_a);
    end
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_count;
    test_saturation;
    test_paging;
    test_reset_measure;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
